// File: rtl/spram_pkg.sv
// Shared types for the spram read-side stream initiator: FSM states,
// output-buffer entry layout and the wrapping address increment.
package spram_pkg;

  // Word width carried by the output buffer; the reader's DATA_WIDTH
  // defaults to this value and must match it.
  localparam int PKG_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } rd_state_t;

  typedef struct packed {
    logic [PKG_DATA_WIDTH-1:0] data;
    logic                      last;
  } obuf_entry_t;

  // Next RAM address with wrap at depth-1, valid for non-power-of-2 depths.
  function automatic int wrap_inc(input int addr, input int depth);
    return (addr == depth - 1) ? 0 : addr + 1;
  endfunction

endpackage : spram_pkg

// File: rtl/spram_rd_obuf.sv
// Small flop-based synchronous FIFO holding returned RAM words and their
// last flags until the downstream consumer accepts them.
module spram_rd_obuf
  import spram_pkg::*;
#(
  parameter int OBUF_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              push_i,
  input  obuf_entry_t                       push_entry_i,
  input  logic                              pop_i,
  output obuf_entry_t                       head_o,
  output logic [$clog2(OBUF_DEPTH+1)-1:0]   occ_o
);

  localparam int OCC_W = $clog2(OBUF_DEPTH + 1);
  localparam int PTR_W = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;

  obuf_entry_t      mem_q [OBUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OBUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Next pointer and occupancy values; a simultaneous push and pop keeps occ.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push_i && !pop_i)      occ_d = occ_q + OCC_W'(1);
    else if (!push_i && pop_i) occ_d = occ_q - OCC_W'(1);
  end

  // Pointer and occupancy registers; reset empties the buffer.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Entry storage write; contents are only meaningful below occ.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; the pointers alone define what is valid.
    if (push_i) mem_q[wr_ptr_q] <= push_entry_i;
  end

  // Overflow and underflow guards; the reader's credit rule must prevent both.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(push_i && !pop_i && occ_q == OCC_W'(OBUF_DEPTH)));
      assert (!(pop_i && occ_q == '0));
    end
  end

  assign head_o = mem_q[rd_ptr_q];
  assign occ_o  = occ_q;

endmodule : spram_rd_obuf

// File: rtl/spram_stream_reader.sv
// Read-side initiator for the single-port RAM: takes (addr, len) commands,
// issues one read per cycle under buffer credit, and streams the words out
// with a last flag on the final beat of each command.
module spram_stream_reader
  import spram_pkg::*;
#(
  parameter int DATA_WIDTH = PKG_DATA_WIDTH,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1,
  parameter int OBUF_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  ram_ena,
  output logic                  ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  input  logic [DATA_WIDTH-1:0] ram_douta,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy
);

  localparam int OCC_W = $clog2(OBUF_DEPTH + 1);

  rd_state_t             state_q;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [LEN_WIDTH-1:0]  remaining_q;
  logic                  inflight_q;
  logic                  inflight_last_q;

  logic [OCC_W-1:0]      occ;
  logic [OCC_W:0]        committed;
  logic                  issue;
  logic                  final_issue;
  logic                  pop;
  obuf_entry_t           push_entry;
  obuf_entry_t           head;

  // Credit check: buffered words plus the word still in the RAM pipeline
  // must leave room for the read issued this cycle.
  always_comb begin
    committed   = {1'b0, occ} + (OCC_W + 1)'(inflight_q);
    issue       = (state_q == READ) && (committed < (OCC_W + 1)'(OBUF_DEPTH));
    final_issue = issue && (remaining_q == LEN_WIDTH'(1));
    cur_addr_d  = ADDR_WIDTH'(wrap_inc(int'(cur_addr_q), FIFO_DEPTH));
  end

  // Command FSM with address/length tracking and the one-deep read pipeline tag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cur_addr_q      <= '0;
      ram_addr_q      <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q      <= issue;
      inflight_last_q <= final_issue;
      if (issue) begin
        ram_addr_q  <= cur_addr_q;
        cur_addr_q  <= cur_addr_d;
        remaining_q <= remaining_q - LEN_WIDTH'(1);
      end
      unique case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_len != '0) begin
            cur_addr_q  <= cmd_addr;
            remaining_q <= cmd_len;
            state_q     <= READ;
          end
        end
        READ: begin
          if (final_issue) state_q <= DRAIN;
        end
        DRAIN: begin
          if (pop && head.last) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Returned word is captured unconditionally the cycle after its read.
  assign push_entry.data = ram_douta;
  assign push_entry.last = inflight_last_q;

  spram_rd_obuf #(
    .OBUF_DEPTH (OBUF_DEPTH)
  ) u_obuf (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (inflight_q),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head),
    .occ_o        (occ)
  );

  assign pop       = m_valid && m_ready;
  assign m_valid   = (occ != '0);
  assign m_data    = m_valid ? head.data : '0;
  assign m_last    = m_valid && head.last;

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);

  assign ram_ena   = issue;
  assign ram_wea   = 1'b0;
  assign ram_addra = issue ? cur_addr_q : ram_addr_q;

endmodule : spram_stream_reader

// File: tb/tb_spram_stream_reader.sv
// Directed bench for spram_stream_reader with a behavioural one-cycle-latency
// RAM preloaded with RAM[i] = 8'hA0 + i.
module tb_spram_stream_reader;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_addr;
  logic [4:0] cmd_len;
  logic       ram_ena;
  logic       ram_wea;
  logic [3:0] ram_addra;
  logic [7:0] ram_douta;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;
  logic       busy;

  int checks;
  int failures;

  logic [7:0] mem [16];

  // Per-run observations.
  logic [7:0] got_d [$];
  logic       got_l [$];
  int         got_c [$];
  logic [3:0] iss_a [$];
  int         iss_c [$];
  int         acc_q [$];
  logic       rdy_q [$];
  int first_v, max_out, n_busy, n_unstable, n_stall, n_ena_stall, n_wea;

  spram_stream_reader #(
    .DATA_WIDTH (8),
    .FIFO_DEPTH (16),
    .ADDR_WIDTH (4),
    .LEN_WIDTH  (5),
    .OBUF_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .ram_ena   (ram_ena),
    .ram_wea   (ram_wea),
    .ram_addra (ram_addra),
    .ram_douta (ram_douta),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-only RAM model: data returns the cycle after the enabled address.
  always @(posedge clk) begin
    if (ram_ena) ram_douta <= mem[ram_addra];
  end

  function automatic logic ready_for(input int mode, input int k);
    if (mode == 1) begin
      if (k >= 3 && k <= 6)  return (k == 3 || k == 5);
      if (k >= 7 && k <= 16) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Drives up to two commands (cmd_valid held until accepted) and records
  // issues, beats and handshake timing for ncyc cycles. Cycle 0 presents the
  // first command. With rst_beat > 0, rst_n is pulled low for the cycle after
  // that many beats and the task returns.
  task automatic run(input int ncmd, input logic [3:0] a0, input logic [4:0] l0,
                     input logic [3:0] a1, input logic [4:0] l1,
                     input int mode, input int ncyc, input int rst_beat);
    int idx;
    int out;
    logic prev_stall;
    logic [7:0] prev_d;
    logic prev_l;
    got_d.delete(); got_l.delete(); got_c.delete();
    iss_a.delete(); iss_c.delete(); acc_q.delete(); rdy_q.delete();
    idx = 0; prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
    first_v = -1; max_out = 0; n_busy = 0; n_unstable = 0;
    n_stall = 0; n_ena_stall = 0; n_wea = 0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (rst_beat > 0 && got_d.size() == rst_beat) begin
        rst_n = 1'b0; m_ready = 1'b0; cmd_valid = 1'b0;
        return;
      end
      if (idx < ncmd) begin
        cmd_valid = 1'b1;
        cmd_addr  = (idx == 0) ? a0 : a1;
        cmd_len   = (idx == 0) ? l0 : l1;
      end else begin
        cmd_valid = 1'b0;
      end
      m_ready = ready_for(mode, k);
      #1;
      rdy_q.push_back(cmd_ready);
      if (busy) n_busy++;
      if (ram_wea) n_wea++;
      if (cmd_valid && cmd_ready) begin
        acc_q.push_back(k);
        idx++;
      end
      if (ram_ena) begin
        iss_a.push_back(ram_addra);
        iss_c.push_back(k);
        if (mode == 1 && k >= 8 && k <= 16) n_ena_stall++;
      end
      out = iss_a.size() - got_d.size();
      if (out > max_out) max_out = out;
      if (prev_stall && (!m_valid || m_data !== prev_d || m_last !== prev_l)) n_unstable++;
      prev_stall = m_valid && !m_ready;
      prev_d = m_data;
      prev_l = m_last;
      if (prev_stall) n_stall++;
      if (m_valid && first_v < 0) first_v = k;
      if (m_valid && m_ready) begin
        got_d.push_back(m_data);
        got_l.push_back(m_last);
        got_c.push_back(k);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
    checks++; if (m_last !== 1'b0) begin failures++; $display("FAIL reset_m_last: got %b expected 0", m_last); end
    checks++; if (ram_ena !== 1'b0) begin failures++; $display("FAIL reset_ram_ena: got %b expected 0", ram_ena); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (m_data !== 8'h00) begin failures++; $display("FAIL reset_m_data: got %h expected 00", m_data); end
    checks++; if (ram_wea !== 1'b0) begin failures++; $display("FAIL reset_ram_wea: got %b expected 0", ram_wea); end
    rst_n = 1'b1;
    @(negedge clk); #1;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_basic();
    run(1, 4'd0, 5'd4, 4'd0, 5'd0, 0, 12, 0);
    checks++; if (acc_q.size() != 1 || acc_q[0] != 0) begin failures++; $display("FAIL basic_accept: got %0d accepts expected 1 at cycle 0", acc_q.size()); end
    checks++; if (iss_c.size() < 1 || iss_c[0] != 1) begin failures++; $display("FAIL basic_first_ena: got %0d issues expected first at cycle 1", iss_c.size()); end
    checks++; if (first_v != 3) begin failures++; $display("FAIL basic_first_valid: got cycle %0d expected 3", first_v); end
    checks++; if (got_d.size() != 4) begin failures++; $display("FAIL basic_count: got %0d beats expected 4", got_d.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= got_d.size() || got_d[i] !== 8'(8'hA0 + i) || got_l[i] !== (i == 3) || got_c[i] != 3 + i) begin
        failures++;
        $display("FAIL basic_beat%0d: got data/last/cycle %h/%b/%0d expected %h/%b/%0d", i,
                 (i < got_d.size()) ? got_d[i] : 8'hxx, (i < got_l.size()) ? got_l[i] : 1'bx,
                 (i < got_c.size()) ? got_c[i] : -1, 8'(8'hA0 + i), (i == 3), 3 + i);
      end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_idle_after: busy got %b expected 0", busy); end
  endtask

  task automatic test_wrap();
    logic [3:0] exp_a [4];
    logic [7:0] exp_d [4];
    exp_a = '{4'd14, 4'd15, 4'd0, 4'd1};
    exp_d = '{8'hAE, 8'hAF, 8'hA0, 8'hA1};
    run(1, 4'd14, 5'd4, 4'd0, 5'd0, 0, 12, 0);
    checks++; if (iss_a.size() != 4) begin failures++; $display("FAIL wrap_issue_count: got %0d expected 4", iss_a.size()); end
    checks++; if (got_d.size() != 4) begin failures++; $display("FAIL wrap_beat_count: got %0d expected 4", got_d.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= iss_a.size() || iss_a[i] !== exp_a[i]) begin
        failures++;
        $display("FAIL wrap_addr%0d: got %0d expected %0d", i, (i < iss_a.size()) ? iss_a[i] : 4'hx, exp_a[i]);
      end
      checks++;
      if (i >= got_d.size() || got_d[i] !== exp_d[i] || got_l[i] !== (i == 3)) begin
        failures++;
        $display("FAIL wrap_beat%0d: got %h expected %h last %b", i, (i < got_d.size()) ? got_d[i] : 8'hxx, exp_d[i], (i == 3));
      end
    end
    checks++; if (ram_addra !== 4'd1) begin failures++; $display("FAIL wrap_addr_hold: got %0d expected 1", ram_addra); end
  endtask

  task automatic test_backpressure();
    int n_last;
    run(1, 4'd0, 5'd16, 4'd0, 5'd0, 1, 45, 0);
    checks++; if (got_d.size() != 16) begin failures++; $display("FAIL bp_count: got %0d beats expected 16", got_d.size()); end
    n_last = 0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (i >= got_d.size() || got_d[i] !== 8'(8'hA0 + i)) begin
        failures++;
        $display("FAIL bp_beat%0d: got %h expected %h", i, (i < got_d.size()) ? got_d[i] : 8'hxx, 8'(8'hA0 + i));
      end
      if (i < got_l.size() && got_l[i] === 1'b1) n_last++;
    end
    checks++; if (got_l.size() != 16 || got_l[15] !== 1'b1 || n_last != 1) begin failures++; $display("FAIL bp_last: got %0d last flags expected 1 on beat 15", n_last); end
    checks++; if (max_out > 4) begin failures++; $display("FAIL bp_outstanding: got %0d expected at most 4", max_out); end
    checks++; if (n_ena_stall != 0) begin failures++; $display("FAIL bp_ena_in_stall: got %0d issues expected 0", n_ena_stall); end
    checks++; if (n_stall == 0) begin failures++; $display("FAIL bp_stall_seen: got %0d stall cycles expected nonzero", n_stall); end
    checks++; if (n_unstable != 0) begin failures++; $display("FAIL bp_stable: got %0d changes expected 0", n_unstable); end
    checks++; if (n_wea != 0) begin failures++; $display("FAIL bp_wea: got %0d cycles high expected 0", n_wea); end
  endtask

  task automatic test_zero_len();
    int n_notready;
    run(1, 4'd5, 5'd0, 4'd0, 5'd0, 0, 8, 0);
    n_notready = 0;
    foreach (rdy_q[i]) if (rdy_q[i] !== 1'b1) n_notready++;
    checks++; if (iss_a.size() != 0) begin failures++; $display("FAIL zero_ena: got %0d issues expected 0", iss_a.size()); end
    checks++; if (first_v != -1) begin failures++; $display("FAIL zero_valid: got m_valid at cycle %0d expected never", first_v); end
    checks++; if (n_notready != 0) begin failures++; $display("FAIL zero_cmd_ready: got %0d low cycles expected 0", n_notready); end
    checks++; if (n_busy != 0) begin failures++; $display("FAIL zero_busy: got %0d busy cycles expected 0", n_busy); end
  endtask

  task automatic test_reset_mid();
    run(1, 4'd0, 5'd16, 4'd0, 5'd0, 0, 40, 5);
    checks++; if (got_d.size() != 5) begin failures++; $display("FAIL rmid_pre_count: got %0d beats expected 5", got_d.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= got_d.size() || got_d[i] !== 8'(8'hA0 + i)) begin
        failures++;
        $display("FAIL rmid_pre_beat%0d: got %h expected %h", i, (i < got_d.size()) ? got_d[i] : 8'hxx, 8'(8'hA0 + i));
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL rmid_m_valid: got %b expected 0", m_valid); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rmid_cmd_ready: got %b expected 1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy: got %b expected 0", busy); end
    run(1, 4'd8, 5'd2, 4'd0, 5'd0, 0, 10, 0);
    checks++; if (got_d.size() != 2) begin failures++; $display("FAIL rmid_post_count: got %0d beats expected 2", got_d.size()); end
    checks++; if (got_d.size() < 2 || got_d[0] !== 8'hA8 || got_l[0] !== 1'b0) begin failures++; $display("FAIL rmid_post_beat0: got %h expected a8 not last", (got_d.size() > 0) ? got_d[0] : 8'hxx); end
    checks++; if (got_d.size() < 2 || got_d[1] !== 8'hA9 || got_l[1] !== 1'b1) begin failures++; $display("FAIL rmid_post_beat1: got %h expected a9 last", (got_d.size() > 1) ? got_d[1] : 8'hxx); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d [5];
    logic       exp_l [5];
    int n_ready_busy;
    exp_d = '{8'hA2, 8'hA3, 8'hA4, 8'hAA, 8'hAB};
    exp_l = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    run(2, 4'd2, 5'd3, 4'd10, 5'd2, 0, 16, 0);
    checks++; if (acc_q.size() != 2 || acc_q[0] != 0 || acc_q[1] != 6) begin failures++; $display("FAIL b2b_accepts: got %0d accepts (second at %0d) expected 2 (second at 6)", acc_q.size(), (acc_q.size() > 1) ? acc_q[1] : -1); end
    n_ready_busy = 0;
    for (int k = 1; k <= 5; k++) if (k < rdy_q.size() && rdy_q[k] !== 1'b0) n_ready_busy++;
    checks++; if (n_ready_busy != 0) begin failures++; $display("FAIL b2b_cmd_ready_busy: got %0d ready cycles expected 0", n_ready_busy); end
    checks++; if (got_d.size() != 5) begin failures++; $display("FAIL b2b_count: got %0d beats expected 5", got_d.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= got_d.size() || got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
        failures++;
        $display("FAIL b2b_beat%0d: got %h/%b expected %h/%b", i, (i < got_d.size()) ? got_d[i] : 8'hxx,
                 (i < got_l.size()) ? got_l[i] : 1'bx, exp_d[i], exp_l[i]);
      end
    end
    checks++; if (got_c.size() < 3 || acc_q.size() < 2 || acc_q[1] != got_c[2] + 1) begin failures++; $display("FAIL b2b_accept_after_last: second accept not the cycle after first last beat"); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    ram_douta = '0;
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'hA0 + i);
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_spram_stream_reader
